// File: rtl/ctrl_bit_skid_feeder_pkg.sv
// Shared types and helpers for the control-bit skid feeder.
package ctrl_bit_skid_feeder_pkg;

    // Field order puts a in bit 0, so a packed 3-bit vector maps
    // directly onto {c, b, a}.
    typedef struct packed {
        logic c;
        logic b;
        logic a;
    } ctrl_bits_t;

    localparam ctrl_bits_t CTRL_DEFAULT = '{c: 1'b0, b: 1'b0, a: 1'b0};

    // A field takes the producer's value only when its mask bit is set.
    // Otherwise it takes the per-field default.
    function automatic ctrl_bits_t resolve(
        input logic [2:0] data,
        input logic [2:0] mask,
        input ctrl_bits_t dflt
    );
        ctrl_bits_t r;
        r.a = mask[0] ? data[0] : dflt.a;
        r.b = mask[1] ? data[1] : dflt.b;
        r.c = mask[2] ? data[2] : dflt.c;
        return r;
    endfunction

endpackage

// File: rtl/ctrl_bit_skid_feeder_if.sv
// Handshake bundle between the producer, the feeder and the consumer.
interface ctrl_bit_skid_feeder_if;
    logic       i_valid;
    logic       o_ready;
    logic [2:0] i_data;
    logic [2:0] i_mask;
    logic       o_valid;
    logic       i_ready;
    logic       o_a;
    logic       o_b;
    logic       o_c;
    logic       i_d;

    // Environment side: it drives the producer and consumer signals.
    modport master (
        output i_valid, i_data, i_mask, i_ready, i_d,
        input  o_ready, o_valid, o_a, o_b, o_c
    );

    // Feeder side.
    modport slave (
        input  i_valid, i_data, i_mask, i_ready, i_d,
        output o_ready, o_valid, o_a, o_b, o_c
    );
endinterface

// File: rtl/ctrl_bit_skid_feeder_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;

    // Next count: clear first, then increment only below the ceiling.
    always_comb begin
        count_s = count_r;
        if (i_clear) begin
            count_s = {WIDTH{1'b0}};
        end else if (i_inc && (count_r != MAX_COUNT)) begin
            count_s = count_r + WIDTH'(1'b1);
        end else begin
            count_s = count_r;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign o_count = count_r;

endmodule

// File: rtl/ctrl_bit_skid_feeder.sv
// Control-bit feeder: resolves masked fields, buffers two words in a
// skid buffer and counts consumer results equal to 1.
module ctrl_bit_skid_feeder
    import ctrl_bit_skid_feeder_pkg::*;
#(
    parameter logic DEFAULT_A = 1'b0,
    parameter logic DEFAULT_B = 1'b0,
    parameter logic DEFAULT_C = 1'b0,
    parameter int   CNT_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clear,
    output logic [CNT_WIDTH-1:0]      o_ones,
    ctrl_bit_skid_feeder_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } occ_state_t;

    localparam ctrl_bits_t DFLT = '{c: DEFAULT_C, b: DEFAULT_B, a: DEFAULT_A};

    occ_state_t state_r, state_s;
    ctrl_bits_t main_r, main_s;
    ctrl_bits_t skid_r, skid_s;
    logic       valid_r, valid_s;
    logic       ready_r, ready_s;
    logic       in_xfer_s;
    logic       out_xfer_s;
    ctrl_bits_t incoming_s;

    assign in_xfer_s  = bus.i_valid & ready_r;
    assign out_xfer_s = valid_r & bus.i_ready;
    assign incoming_s = resolve(bus.i_data, bus.i_mask, DFLT);

    // Occupancy next-state and entry updates. Main returns to the defaults
    // whenever the buffer empties, so idle outputs never show stale data.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    main_s  = incoming_s;
                    state_s = ST_ONE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                case ({in_xfer_s, out_xfer_s})
                    2'b10: begin
                        skid_s  = incoming_s;
                        state_s = ST_TWO;
                    end
                    2'b01: begin
                        main_s  = DFLT;
                        state_s = ST_EMPTY;
                    end
                    2'b11: begin
                        main_s  = incoming_s;
                        state_s = ST_ONE;
                    end
                    default: begin
                        state_s = ST_ONE;
                    end
                endcase
            end
            ST_TWO: begin
                if (out_xfer_s) begin
                    main_s  = skid_r;
                    skid_s  = DFLT;
                    state_s = ST_ONE;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                main_s  = DFLT;
                skid_s  = DFLT;
                state_s = ST_EMPTY;
            end
        endcase
        valid_s = (state_s != ST_EMPTY);
        ready_s = (state_s != ST_TWO);
    end

    // State, buffer entries and handshake outputs are all registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_EMPTY;
            main_r  <= DFLT;
            skid_r  <= DFLT;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            main_r  <= main_s;
            skid_r  <= skid_s;
            valid_r <= valid_s;
            ready_r <= ready_s;
        end
    end

    assign bus.o_valid = valid_r;
    assign bus.o_ready = ready_r;
    assign bus.o_a     = main_r.a;
    assign bus.o_b     = main_r.b;
    assign bus.o_c     = main_r.c;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_ones (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (out_xfer_s & bus.i_d),
        .o_count (o_ones)
    );

endmodule

// File: tb/tb_ctrl_bit_skid_feeder.sv
// Directed bench for ctrl_bit_skid_feeder (DEFAULT_B=1, CNT_WIDTH=2).
module tb_ctrl_bit_skid_feeder;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [1:0] ones;
    int         n_vec;
    int         n_err;

    ctrl_bit_skid_feeder_if bus();

    ctrl_bit_skid_feeder #(
        .DEFAULT_A (1'b0),
        .DEFAULT_B (1'b1),
        .DEFAULT_C (1'b0),
        .CNT_WIDTH (2)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (clear),
        .o_ones  (ones),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] abc();
        return {bus.o_c, bus.o_b, bus.o_a};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        clear = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = 3'b000;
        bus.i_mask = 3'b000;
        bus.i_ready = 1'b0;
        bus.i_d = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_abc", 32'(abc()), 32'h2);
        check("rst_ones", 32'(ones), 32'd0);

        // Full mask, one-cycle latency
        bus.i_valid = 1'b1; bus.i_data = 3'b101; bus.i_mask = 3'b111; bus.i_ready = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        check("t1_valid", 32'(bus.o_valid), 32'd1);
        check("t1_abc", 32'(abc()), 32'h5);
        check("t1_ready", 32'(bus.o_ready), 32'd1);
        tick();
        check("t1_drain_valid", 32'(bus.o_valid), 32'd0);
        check("t1_drain_abc", 32'(abc()), 32'h2);

        // Masked field b takes its default of 1
        bus.i_valid = 1'b1; bus.i_data = 3'b000; bus.i_mask = 3'b101; bus.i_ready = 1'b0;
        tick();
        bus.i_valid = 1'b0;
        check("t2_abc", 32'(abc()), 32'h2);
        check("t2_valid", 32'(bus.o_valid), 32'd1);
        bus.i_ready = 1'b1;
        tick();
        check("t2_drain_valid", 32'(bus.o_valid), 32'd0);

        // Fill the skid buffer while the consumer stalls
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_data = 3'b001; bus.i_mask = 3'b111;
        tick();
        check("t3_w0_ready", 32'(bus.o_ready), 32'd1);
        bus.i_data = 3'b110;
        tick();
        check("t3_full_ready", 32'(bus.o_ready), 32'd0);
        check("t3_full_abc", 32'(abc()), 32'h1);
        bus.i_data = 3'b011;
        tick();
        bus.i_valid = 1'b0;
        check("t3_stall_abc", 32'(abc()), 32'h1);
        check("t3_stall_ready", 32'(bus.o_ready), 32'd0);
        bus.i_ready = 1'b1;
        tick();
        check("t3_w1_abc", 32'(abc()), 32'h6);
        check("t3_w1_ready", 32'(bus.o_ready), 32'd1);
        tick();
        check("t3_empty_valid", 32'(bus.o_valid), 32'd0);
        check("t3_empty_abc", 32'(abc()), 32'h2);

        // Saturating result counter
        bus.i_valid = 1'b1; bus.i_data = 3'b111; bus.i_mask = 3'b111;
        bus.i_ready = 1'b1; bus.i_d = 1'b1;
        tick();
        check("t4_first_ones", 32'(ones), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_ones", 32'(ones), (i < 2) ? 32'(i + 1) : 32'd3);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.i_valid = 1'b0;
        check("t4_clear_ones", 32'(ones), 32'd0);
        tick();
        bus.i_d = 1'b0;
        check("t4_after_clear_ones", 32'(ones), 32'd1);
        check("t4_after_clear_valid", 32'(bus.o_valid), 32'd0);

        // Reset while holding two words
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_data = 3'b101; bus.i_mask = 3'b111;
        tick();
        tick();
        bus.i_valid = 1'b0;
        check("t5_full_ready", 32'(bus.o_ready), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_rst_valid", 32'(bus.o_valid), 32'd0);
        check("t5_rst_ready", 32'(bus.o_ready), 32'd1);
        check("t5_rst_abc", 32'(abc()), 32'h2);
        check("t5_rst_ones", 32'(ones), 32'd0);
        bus.i_ready = 1'b1;
        tick();
        check("t5_no_reappear", 32'(bus.o_valid), 32'd0);

        // Streaming: one word per cycle in order
        bus.i_valid = 1'b1; bus.i_mask = 3'b111; bus.i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.i_data = 3'(k);
            tick();
            check("t6_abc", 32'(abc()), 32'(k % 8));
            check("t6_ready", 32'(bus.o_ready), 32'd1);
        end
        bus.i_valid = 1'b0;
        tick();
        check("t6_drain_valid", 32'(bus.o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_bit_skid_feeder.md
Name: ctrl_bit_skid_feeder

Overview:
- Upstream feeder for the three-input/one-output control-bit consumer modules (inputs i_a, i_b, i_c; output o_d).
- Accepts 3-bit control words over a valid/ready handshake and substitutes a per-field default for any field the producer leaves undriven.
- Buffers words in a 2-entry skid buffer and presents them to the consumer.
- Samples the consumer's o_d result on every transfer and keeps a saturating count of results equal to 1.

Parameters:
- DEFAULT_A, 1'b0: value driven on o_a when the field is masked off or no word is held.
- DEFAULT_B, 1'b0: same for o_b.
- DEFAULT_C, 1'b0: same for o_c.
- CNT_WIDTH, 8: width of the result counter; legal range 1..32.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: synchronous active-low reset.
- i_valid, input, 1: upstream word valid.
- o_ready, output, 1: feeder can accept a word.
- i_data, input, 3: upstream field values; [0]=a, [1]=b, [2]=c.
- i_mask, input, 3: 1 means the field is driven by i_data; 0 means use DEFAULT_x.
- o_valid, output, 1: word presented to the consumer.
- i_ready, input, 1: consumer accepts the word.
- o_a, output, 1: field a to the consumer's i_a.
- o_b, output, 1: field b to the consumer's i_b.
- o_c, output, 1: field c to the consumer's i_c.
- i_d, input, 1: consumer result (its o_d), sampled on an output transfer.
- i_clear, input, 1: synchronous clear of the result counter.
- o_ones, output, CNT_WIDTH: saturating count of transfers with i_d=1.

Behaviour:
- Transfers:
  - Input transfer = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
- Field resolution at input-transfer time: field_x = i_mask[x] ? i_data[x] : DEFAULT_x. Only resolved values are stored.
- Storage: main entry (drives outputs) plus skid entry. Occupancy state machine:
  - EMPTY: o_valid=0. Input transfer → ONE.
  - ONE: o_valid=1.
    - Input transfer with no output transfer → TWO (word goes to skid).
    - Output transfer with no input transfer → EMPTY.
    - Both in the same cycle → stay ONE; main is loaded with the new word.
  - TWO: o_ready=0.
    - Output transfer → ONE; skid moves to main.
    - No input transfer is possible in this state.
- o_ready is a register: 1 in EMPTY/ONE, 0 in TWO. It is never combinationally dependent on i_ready.
- o_valid is a register: 1 in ONE/TWO.
- Latency: a word accepted into an empty feeder appears on o_valid/o_a..o_c the next cycle.
- Ordering: words leave in strict FIFO order; none are dropped or duplicated.
- When o_valid=0, o_a/o_b/o_c equal DEFAULT_A/B/C (never stale data).
- o_a/o_b/o_c hold stable while o_valid=1 and i_ready=0.
- Counter:
  - On an output transfer with i_d=1, o_ones increments by 1.
  - It saturates at 2^CNT_WIDTH-1 with no wrap.
  - i_clear=1 forces o_ones to 0 and overrides a same-cycle increment (that result is discarded).
  - i_clear does not affect the buffer.
- Reset (i_rst=0 at a clock edge):
  - State → EMPTY, o_valid=0, o_ready=1, o_a/b/c = defaults, o_ones=0.
  - Buffered words are discarded.
  - While i_rst=0, handshakes are ignored and no transfer occurs.
- i_data/i_mask are ignored when i_valid=0. i_d is ignored unless an output transfer occurs.

Decomposition:
- Shared package:
  - struct ctrl_bits_t {a, b, c}.
  - Localparam CTRL_DEFAULT of type ctrl_bits_t (all 0).
  - Function resolve(data, mask, dflt) returning ctrl_bits_t.
- Sub-module sat_counter (parameter WIDTH; ports i_clk, i_rst, i_clear, i_inc, o_count) holds the counter.
- The skid buffer stays inline.

Test Plan:
- Reset, then i_valid=1, i_data=3'b101, i_mask=3'b111, i_ready=1 → next cycle o_valid=1, o_a=1, o_b=0, o_c=1; o_ready stays 1.
- DEFAULT_B=1, i_data=3'b000, i_mask=3'b101 → o_a=0, o_b=1, o_c=0 presented.
- i_ready=0, push words W0, W1 → o_ready=0 after the second accept. Then i_ready=1 for 2 cycles → W0 then W1 emitted in order, o_ready returns to 1. A third push attempted while full is not accepted.
- CNT_WIDTH=2, 5 transfers with i_d=1 → o_ones sequence 1,2,3,3,3. Then i_clear=1 together with a transfer with i_d=1 → o_ones=0.
- Buffer in TWO, assert i_rst=0 for one cycle → o_valid=0, o_ready=1, o_a..o_c=defaults, o_ones=0; no buffered word reappears.
- Continuous i_valid=1 and i_ready=1 for 16 cycles with incrementing data → one word out per cycle, order preserved, o_ready never drops.
